ms_timer_ctrl: RTL and testbench
================================

MS_TIMER_CTRL -- requirements
Module: ms_timer_ctrl

Interface
REQ-001 Parameter CLK_PER_MS, default 5000: clk cycles per millisecond tick; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the elapsed, target and lap counters.
REQ-003 clk  input  1  system clock; all registers update on the falling edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a falling edge.
REQ-007 cmd_op  input  2  command: 00 START, 01 STOP, 10 CLEAR, 11 LOAD.
REQ-008 cmd_data  input  CNT_W  LOAD target in ms; 0 means free-run with no target.
REQ-009 lap_req  input  1  lap capture strobe; used only with MS_TIMER_LAP_EN.
REQ-010 ms_tick  output  1  one-cycle pulse per elapsed millisecond while running.
REQ-011 elapsed_ms  output  CNT_W  milliseconds counted since the last START from IDLE.
REQ-012 lap_ms  output  CNT_W  elapsed_ms captured at the last lap.
REQ-013 state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
REQ-014 done  output  1  one-cycle pulse on entry to DONE.
REQ-015 cmd_err  output  1  one-cycle pulse when an accepted command is illegal in the current state.

Function
REQ-016 The prescaler SHALL count 0..CLK_PER_MS-1 only in RUN; ms_tick SHALL be high when the prescaler equals CLK_PER_MS-1 in RUN, and the prescaler SHALL then wrap to 0.
REQ-017 cmd_ready SHALL be 1 in every state outside reset; every command is consumed in one cycle.
REQ-018 IDLE + START SHALL go to RUN with prescaler=0 and elapsed_ms=0; the first ms_tick occurs CLK_PER_MS cycles after acceptance.
REQ-019 RUN + STOP SHALL go to PAUSE, freezing the prescaler and elapsed_ms.
REQ-020 PAUSE + START SHALL return to RUN, resuming from the held prescaler value.
REQ-021 CLEAR SHALL be legal in every state: go to IDLE, clear the prescaler and elapsed_ms, keep the target.
REQ-022 LOAD SHALL be legal only in IDLE and DONE: it stores cmd_data into the target and goes to IDLE from DONE.
REQ-023 In RUN, each ms_tick SHALL increment elapsed_ms; with target!=0 and elapsed_ms+1==target, the next state is DONE and done pulses in the same cycle.
REQ-024 With target==0, elapsed_ms SHALL saturate at 2^CNT_W-1, stay in RUN, and ms_tick SHALL continue.
REQ-025 DONE SHALL hold elapsed_ms==target; only CLEAR or LOAD leave DONE.
REQ-026 Illegal commands (START in RUN/DONE, STOP outside RUN, LOAD in RUN/PAUSE) SHALL be ignored and pulse cmd_err.
REQ-027 An ms_tick and STOP in the same cycle SHALL apply the increment, then enter PAUSE; if that increment reaches the target, DONE SHALL win and STOP SHALL be ignored without cmd_err.
REQ-028 An ms_tick and CLEAR in the same cycle SHALL apply CLEAR only; no increment and no done pulse.

Reset
REQ-029 While rst is high: state=IDLE, prescaler=0, elapsed_ms=0, target=0, lap_ms=0, and cmd_ready, ms_tick, done and cmd_err are all 0.
REQ-030 rst asserted mid-operation SHALL abort immediately with no done pulse; after release, the block waits in IDLE for START.

Configuration
REQ-031 Macro MS_TIMER_LAP_EN defined: lap_req high in RUN or PAUSE SHALL load lap_ms with the post-update elapsed_ms of that cycle; CLEAR SHALL zero lap_ms.
REQ-032 Macro MS_TIMER_LAP_EN undefined: the lap register is not built, lap_ms is constant 0, and lap_req is ignored.

Verification (CLK_PER_MS=4)
REQ-033 Reset, LOAD 3, START -> ticks at cycles 4, 8, 12 after START; elapsed_ms 1, 2, 3; state=DONE and done pulse at cycle 12.
REQ-034 LOAD 0, START, STOP after 6 cycles, START after 10 more cycles -> elapsed_ms=1 during PAUSE; the next tick comes 2 cycles after resume.
REQ-035 STOP issued in the tick cycle with target=2 at elapsed_ms=1 -> DONE, done=1, cmd_err=0.
REQ-036 CLEAR in a tick cycle -> IDLE, elapsed_ms=0, no increment; START in RUN and LOAD in PAUSE -> cmd_err pulse, state unchanged.
REQ-037 CNT_W=4, target=0, run 20 ms -> elapsed_ms holds at 15 and ms_tick continues; rst mid-run -> all outputs 0 asynchronously.
REQ-038 With MS_TIMER_LAP_EN, lap_req at elapsed_ms=5 -> lap_ms=5 while elapsed_ms keeps counting; without the macro, lap_ms stays 0.

Source files
------------

// File: rtl/ms_timer_ctrl.sv
// ms_timer_ctrl: millisecond stopwatch/countdown controller with command port.
// All state updates on the falling edge of clk; rst is async, active-high.
//
// Ports:
//   clk, rst             clock (falling-edge active), async active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is 1 outside reset
//   cmd_op [1:0]         00 START, 01 STOP, 10 CLEAR, 11 LOAD
//   cmd_data [CNT_W]     LOAD target in ms (0 = free-run, no target)
//   lap_req              lap capture strobe (MS_TIMER_LAP_EN builds only)
//   ms_tick              one-cycle pulse per elapsed ms while running
//   elapsed_ms [CNT_W]   ms counted since the last START from IDLE
//   lap_ms [CNT_W]       elapsed_ms captured at the last lap (0 when not built)
//   state [1:0]          00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done                 one-cycle pulse on entry to DONE
//   cmd_err              one-cycle pulse for an accepted illegal command
//
// Build option: define MS_TIMER_LAP_EN to build the lap capture register.

module ms_timer_ctrl #(
    parameter int unsigned CLK_PER_MS = 5000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    input  logic             lap_req,
    output logic             ms_tick,
    output logic [CNT_W-1:0] elapsed_ms,
    output logic [CNT_W-1:0] lap_ms,
    output logic [1:0]       state,
    output logic             done,
    output logic             cmd_err
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam int unsigned PW = $clog2(CLK_PER_MS);

    localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [PW-1:0]    r_pre;
    logic [PW-1:0]    w_pre_nxt;
    logic [CNT_W-1:0] r_elapsed;
    logic [CNT_W-1:0] w_elapsed_nxt;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] w_target_nxt;

    logic w_acc;
    logic w_tick;
    logic w_hit;
    logic w_clear;
    logic w_illegal;

    // Handshake is always open except while reset is held.
    assign cmd_ready = ~rst;
    assign w_acc     = cmd_valid & cmd_ready;
    assign w_clear   = w_acc & (cmd_op == OP_CLEAR);

    assign w_tick = (r_state == S_RUN) && (r_pre == PRE_LAST);

    // This tick completes the programmed count.
    assign w_hit = w_tick && (r_target != '0)
                   && ((r_elapsed + CNT_ONE) == r_target);

    always_comb begin
        w_illegal = 1'b0;
        case (cmd_op)
            OP_START: w_illegal = (r_state == S_RUN) || (r_state == S_DONE);
            OP_STOP:  w_illegal = (r_state != S_RUN);
            OP_CLEAR: w_illegal = 1'b0;
            OP_LOAD:  w_illegal = (r_state == S_RUN) || (r_state == S_PAUSE);
            default:  w_illegal = 1'b0;
        endcase
    end

    assign ms_tick    = w_tick;
    // CLEAR in the completing cycle suppresses the done pulse.
    assign done       = w_hit & ~w_clear;
    assign cmd_err    = w_acc & w_illegal;
    assign state      = r_state;
    assign elapsed_ms = r_elapsed;

    always_comb begin
        w_state_nxt   = r_state;
        w_pre_nxt     = r_pre;
        w_elapsed_nxt = r_elapsed;
        w_target_nxt  = r_target;

        // Counting happens first; the command below then overrides it.
        if (r_state == S_RUN) begin
            if (w_tick) begin
                w_pre_nxt = '0;
                if (w_hit) begin
                    w_elapsed_nxt = r_target;
                    w_state_nxt   = S_DONE;
                end else if (r_elapsed != CNT_MAX) begin
                    w_elapsed_nxt = r_elapsed + CNT_ONE;
                end
            end else begin
                w_pre_nxt = r_pre + PRE_ONE;
            end
        end

        if (w_acc && !w_illegal) begin
            case (cmd_op)
                OP_START: begin
                    if (r_state == S_IDLE) begin
                        w_pre_nxt     = '0;
                        w_elapsed_nxt = '0;
                    end
                    w_state_nxt = S_RUN;
                end
                OP_STOP: begin
                    // Reaching the target in the same cycle wins.
                    if (!w_hit) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                OP_CLEAR: begin
                    w_state_nxt   = S_IDLE;
                    w_pre_nxt     = '0;
                    w_elapsed_nxt = '0;
                end
                OP_LOAD: begin
                    w_target_nxt = cmd_data;
                    w_state_nxt  = S_IDLE;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_elapsed <= '0;
            r_target  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_elapsed <= w_elapsed_nxt;
            r_target  <= w_target_nxt;
        end
    end

`ifdef MS_TIMER_LAP_EN
    logic [CNT_W-1:0] r_lap;

    // Captures the value elapsed_ms takes after this edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_lap <= '0;
        end else if (w_clear) begin
            r_lap <= '0;
        end else if (lap_req &&
                     ((r_state == S_RUN) || (r_state == S_PAUSE))) begin
            r_lap <= w_elapsed_nxt;
        end
    end

    assign lap_ms = r_lap;
`else
    logic w_unused_lap;

    assign w_unused_lap = lap_req;
    assign lap_ms       = '0;
`endif

endmodule

// File: tb/tb_ms_timer_ctrl.sv
// tb_ms_timer_ctrl: randomized + directed bench for ms_timer_ctrl.
// Reference model tracks cycles spent running and derives ms by division.

module tb_ms_timer_ctrl;

    localparam int P    = 4;
    localparam int W    = 4;
    localparam int MAXV = 15;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op    = 2'b00;
    logic [W-1:0] cmd_data  = '0;
    logic         lap_req   = 1'b0;

    logic         cmd_ready;
    logic         ms_tick;
    logic [W-1:0] elapsed_ms;
    logic [W-1:0] lap_ms;
    logic [1:0]   state;
    logic         done;
    logic         cmd_err;

    ms_timer_ctrl #(
        .CLK_PER_MS(P),
        .CNT_W     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .lap_req   (lap_req),
        .ms_tick   (ms_tick),
        .elapsed_ms(elapsed_ms),
        .lap_ms    (lap_ms),
        .state     (state),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: m_st uses the output state codes, m_run counts RUN cycles
    // since START from IDLE, so elapsed = run/P (saturated).
    int m_st  = 0;
    int m_run = 0;
    int m_tgt = 0;
    int m_lap = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_el();
        int v;
        v = m_run / P;
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_reset();
        m_st  = 0;
        m_run = 0;
        m_tgt = 0;
        m_lap = 0;
    endtask

    task automatic cycle(input logic v, input logic [1:0] op,
                         input int d, input logic lr);
        logic tick;
        logic hit;
        logic clr;
        logic ill;
        int   st0;
        @(posedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = W'(d);
        lap_req   = lr;
        #1;
        tick = (m_st == 1) && ((m_run % P) == P - 1);
        hit  = tick && (m_tgt != 0) && (((m_run + 1) / P) == m_tgt);
        clr  = v && (op == 2'b10);
        case (op)
            2'b00:   ill = (m_st == 1) || (m_st == 3);
            2'b01:   ill = (m_st != 1);
            2'b10:   ill = 1'b0;
            default: ill = (m_st == 1) || (m_st == 2);
        endcase
        chk("ready",   32'(cmd_ready),  32'd1);
        chk("state",   32'(state),      32'(m_st));
        chk("elapsed", 32'(elapsed_ms), 32'(m_el()));
        chk("lap",     32'(lap_ms),     32'(m_lap));
        chk("tick",    32'(ms_tick),    32'(tick));
        chk("done",    32'(done),       32'(hit && !clr));
        chk("cmd_err", 32'(cmd_err),    32'(v && ill));
        @(negedge clk);
        if (clr) begin
            m_st  = 0;
            m_run = 0;
            m_lap = 0;
        end else begin
            st0 = m_st;
            if (m_st == 1) begin
                m_run++;
                if (hit) m_st = 3;
            end
            if (v && !ill) begin
                case (op)
                    2'b00: begin
                        if (st0 == 0) m_run = 0;
                        m_st = 1;
                    end
                    2'b01: if (!hit) m_st = 2;
                    2'b11: begin
                        m_tgt = d;
                        m_st  = 0;
                    end
                    default: ;
                endcase
            end
`ifdef MS_TIMER_LAP_EN
            if (lr && (st0 == 1 || st0 == 2)) m_lap = m_el();
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 0, 1'b0);
    endtask

    task automatic cmd(input logic [1:0] op, input int d);
        cycle(1'b1, op, d, 1'b0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_state"},   32'(state),      32'd0);
        chk({tag, "_elapsed"}, 32'(elapsed_ms), 32'd0);
        chk({tag, "_lap"},     32'(lap_ms),     32'd0);
        chk({tag, "_tick"},    32'(ms_tick),    32'd0);
        chk({tag, "_done"},    32'(done),       32'd0);
        chk({tag, "_err"},     32'(cmd_err),    32'd0);
        chk({tag, "_ready"},   32'(cmd_ready),  32'd0);
    endtask

    // Assert rst between edges with a STOP pending; outputs must drop now.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outs(tag);
        model_reset();
        @(negedge clk);
        #1;
        check_reset_outs({tag, "_hold"});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        int r;
        #2;
        check_reset_outs("rst0");
        @(posedge clk);
        #3;
        rst = 1'b0;

        // LOAD 3, START: ticks at 4, 8, 12; DONE at 12.
        cmd(2'b11, 3);
        cmd(2'b00, 0);
        idle(15);

        // Free-run pause/resume keeps prescaler phase.
        cmd(2'b10, 0);
        cmd(2'b11, 0);
        cmd(2'b00, 0);
        idle(5);
        cmd(2'b01, 0);
        idle(9);
        cmd(2'b00, 0);
        idle(6);

        // STOP in the completing tick: DONE wins, no error.
        cmd(2'b10, 0);
        cmd(2'b11, 2);
        cmd(2'b00, 0);
        idle(7);
        cmd(2'b01, 0);
        idle(2);
        cmd(2'b00, 0);
        cmd(2'b01, 0);
        cmd(2'b11, 1);

        // CLEAR in a tick cycle, then illegal commands.
        cmd(2'b11, 0);
        cmd(2'b00, 0);
        idle(3);
        cmd(2'b10, 0);
        cmd(2'b00, 0);
        idle(2);
        cmd(2'b00, 0);
        cmd(2'b11, 5);
        cmd(2'b01, 0);
        cmd(2'b11, 5);
        cmd(2'b01, 0);
        cmd(2'b00, 0);
        idle(2);

        // Saturation at 15 with ticks continuing, then async reset.
        cmd(2'b10, 0);
        cmd(2'b00, 0);
        idle(20 * P + 6);
        mid_reset("rst_mid");

        // Lap capture at elapsed 5 (lap_ms stays 0 without the lap build).
        cmd(2'b00, 0);
        idle(5 * P - 1);
        cycle(1'b0, 2'b00, 0, 1'b1);
        idle(2 * P);
        cmd(2'b01, 0);
        cycle(1'b0, 2'b00, 0, 1'b1);
        cycle(1'b1, 2'b10, 0, 1'b1);

        // Random traffic; targets kept small so DONE is reached often.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                cycle(1'b0, 2'b00, 0, ($urandom_range(0, 9) == 0));
            end else begin
                cycle(1'b1, 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) == 0));
            end
        end
        mid_reset("rst_end");
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
